// File: rtl/vetris_pkg.sv
// Shared types for the move sequencer: move opcodes and sequencer states.
// ST_DROP only exists when VETRIS_HARD_DROP_EN is defined.
package vetris_pkg;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_LEFT,
    OP_RIGHT,
    OP_ROT,
    OP_DOWN
  } move_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOCK
`ifdef VETRIS_HARD_DROP_EN
    , ST_DROP
`endif
  } seq_state_e;

endpackage

// File: rtl/move_sequencer_if.sv
// Move request channel between the sequencer (master) and the collision checker (slave).
// valid/ack: master raises mv_valid with a stable mv_op and holds both until the cycle
// mv_ack=1; mv_ok is meaningful only in that cycle, and the request is consumed on that edge.
interface move_sequencer_if;
  import vetris_pkg::*;

  logic     mv_valid;
  move_op_t mv_op;
  logic     mv_ack;
  logic     mv_ok;

  modport master (output mv_valid, output mv_op, input mv_ack, input mv_ok);
  modport slave  (input mv_valid, input mv_op, output mv_ack, output mv_ok);

endinterface

// File: rtl/move_sequencer_key_repeat.sv
// Rising-edge detect plus DAS/ARR auto-repeat for one held key.
// evt fires on the press edge, DAS_DELAY cycles later, then every ARR_PERIOD cycles.
module key_repeat #(
  parameter int unsigned DAS_DELAY  = 8_000_000,
  parameter int unsigned ARR_PERIOD = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic evt
);

  logic        btn_q, btn_d;
  logic        rep_q, rep_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] cnt_inc;
  logic [31:0] period;

  always_comb begin
    btn_d   = btn;
    rep_d   = rep_q;
    cnt_d   = cnt_q;
    evt     = 1'b0;
    cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
    period  = rep_q ? ARR_PERIOD : DAS_DELAY;

    if (!btn) begin
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (!btn_q) begin
      evt   = 1'b1;
      cnt_d = '0;
      rep_d = 1'b0;
    end else if (cnt_inc == period) begin
      // first match ends the DAS wait; later matches are ARR repeats
      evt   = 1'b1;
      cnt_d = '0;
      rep_d = 1'b1;
    end else begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q <= 1'b0;
      rep_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      btn_q <= btn_d;
      rep_q <= rep_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/move_sequencer.sv
// Arbitrates gravity ticks and key events into one move request at a time toward the
// collision checker; hard drop exists only when VETRIS_HARD_DROP_EN is defined.
module move_sequencer
  import vetris_pkg::*;
#(
  parameter int unsigned DAS_DELAY  = 8_000_000,
  parameter int unsigned ARR_PERIOD = 2_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                move_down_tick,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_rot,
  input  logic                btn_down,
  input  logic                btn_drop,
  input  logic                piece_active,
  move_sequencer_if.master    mv,
  output logic                rst_timer,
  output logic                lock_piece,
  output logic                busy,
  output seq_state_e          dbg_state
);

  seq_state_e state_q, state_d;
  move_op_t   op_q, op_d;
  logic       valid_q, valid_d;
  logic       grav_q, grav_d;
  logic       is_grav_q, is_grav_d;
  logic       rst_timer_q, rst_timer_d;
  logic       lock_q, lock_d;
  logic       rot_q, rot_d;
  logic       down_q, down_d;

  logic       left_evt, right_evt, rot_evt, down_evt, grav_now;
  logic       issue;
  move_op_t   issue_op;

`ifdef VETRIS_HARD_DROP_EN
  logic       drop_q, drop_d;
  logic       drop_evt;
  assign drop_evt = btn_drop & ~drop_q;
`else
  logic       unused_btn_drop;
  assign unused_btn_drop = btn_drop;
`endif

  key_repeat #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD)) u_left (
    .clk(clk), .rst(rst), .btn(btn_left), .evt(left_evt)
  );
  key_repeat #(.DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD)) u_right (
    .clk(clk), .rst(rst), .btn(btn_right), .evt(right_evt)
  );

  assign rot_evt  = btn_rot & ~rot_q;
  assign down_evt = btn_down & ~down_q;
  // a tick arriving in the arbitration cycle itself already counts as pending
  assign grav_now = grav_q | move_down_tick;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    valid_d     = valid_q;
    grav_d      = grav_q | move_down_tick;
    is_grav_d   = is_grav_q;
    rst_timer_d = 1'b0;
    lock_d      = 1'b0;
    rot_d       = btn_rot;
    down_d      = btn_down;
`ifdef VETRIS_HARD_DROP_EN
    drop_d      = btn_drop;
`endif
    issue       = 1'b0;
    issue_op    = OP_NONE;

    case (state_q)
      ST_IDLE: begin
        if (piece_active) begin
          if (grav_now) begin
            issue     = 1'b1;
            issue_op  = OP_DOWN;
            is_grav_d = 1'b1;
            grav_d    = 1'b0;
`ifdef VETRIS_HARD_DROP_EN
          end else if (drop_evt) begin
            state_d   = ST_DROP;
            valid_d   = 1'b1;
            op_d      = OP_DOWN;
            is_grav_d = 1'b0;
            grav_d    = 1'b0;
`endif
          end else if (rot_evt) begin
            issue    = 1'b1;
            issue_op = OP_ROT;
          end else if (left_evt && !right_evt) begin
            issue    = 1'b1;
            issue_op = OP_LEFT;
          end else if (right_evt && !left_evt) begin
            issue    = 1'b1;
            issue_op = OP_RIGHT;
          end else if (down_evt) begin
            issue    = 1'b1;
            issue_op = OP_DOWN;
          end
          if (issue) begin
            state_d = ST_REQ;
            valid_d = 1'b1;
            op_d    = issue_op;
            if (issue_op != OP_DOWN || !grav_now) is_grav_d = 1'b0;
          end
        end
      end

      ST_REQ: begin
        if (mv.mv_ack) begin
          valid_d = 1'b0;
          op_d    = OP_NONE;
          state_d = ST_IDLE;
          if (op_q == OP_DOWN) begin
            if (!mv.mv_ok) begin
              lock_d      = 1'b1;
              rst_timer_d = 1'b1;
              state_d     = ST_LOCK;
            end else if (!is_grav_q) begin
              rst_timer_d = 1'b1;
            end
          end
        end
      end

`ifdef VETRIS_HARD_DROP_EN
      ST_DROP: begin
        // successful steps keep mv_valid high so the next DOWN follows back-to-back
        if (mv.mv_ack && !mv.mv_ok) begin
          valid_d     = 1'b0;
          op_d        = OP_NONE;
          lock_d      = 1'b1;
          rst_timer_d = 1'b1;
          state_d     = ST_LOCK;
        end
      end
`endif

      ST_LOCK: begin
        if (!piece_active) state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        op_d    = OP_NONE;
      end
    endcase

    if (!piece_active) grav_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NONE;
      valid_q     <= 1'b0;
      grav_q      <= 1'b0;
      is_grav_q   <= 1'b0;
      rst_timer_q <= 1'b0;
      lock_q      <= 1'b0;
      rot_q       <= 1'b0;
      down_q      <= 1'b0;
`ifdef VETRIS_HARD_DROP_EN
      drop_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      valid_q     <= valid_d;
      grav_q      <= grav_d;
      is_grav_q   <= is_grav_d;
      rst_timer_q <= rst_timer_d;
      lock_q      <= lock_d;
      rot_q       <= rot_d;
      down_q      <= down_d;
`ifdef VETRIS_HARD_DROP_EN
      drop_q      <= drop_d;
`endif
    end
  end

  assign mv.mv_valid = valid_q;
  assign mv.mv_op    = op_q;
  assign rst_timer   = rst_timer_q;
  assign lock_piece  = lock_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a checker model that acks 2 cycles after valid.
module tb_move_sequencer;
  import vetris_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       move_down_tick = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0;
  logic       btn_down = 1'b0, btn_drop = 1'b0;
  logic       piece_active = 1'b1;
  logic       rst_timer, lock_piece, busy;
  seq_state_e dbg_state;

  move_sequencer_if mv_if();

  move_sequencer #(.DAS_DELAY(4), .ARR_PERIOD(2)) dut (
    .clk(clk), .rst(rst), .move_down_tick(move_down_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_rot(btn_rot),
    .btn_down(btn_down), .btn_drop(btn_drop), .piece_active(piece_active),
    .mv(mv_if), .rst_timer(rst_timer), .lock_piece(lock_piece),
    .busy(busy), .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [2:0] exp_q[$];
  logic       ok_q[$];
  int         rise_q[$];
  logic       chk_ok = 1'b1;
  int         req_cnt = 0;
  int         rst_cnt = 0;
  int         lock_cnt = 0;
  int         last_ack_cyc = -10;

  // ---------------- clock / reset ----------------
  initial forever #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  initial begin
    #50000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- checker model (slave side) ----------------
  initial begin
    int       age;
    logic     ack_prev;
    logic [2:0] held_op;
    age = 0;
    held_op = '0;
    mv_if.mv_ack = 1'b0;
    mv_if.mv_ok  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mv_if.mv_ack = 1'b0;
        mv_if.mv_ok  = 1'b0;
        age = 0;
      end else begin
        ack_prev = mv_if.mv_ack;
        mv_if.mv_ack = 1'b0;
        mv_if.mv_ok  = 1'b0;
        if (ack_prev) age = 0;
        if (mv_if.mv_valid) begin
          if (age == 0) held_op = mv_if.mv_op;
          else check("op_stable", mv_if.mv_op, held_op);
          if (age == 2) begin
            mv_if.mv_ack = 1'b1;
            mv_if.mv_ok  = (ok_q.size() > 0) ? ok_q.pop_front() : chk_ok;
            req_cnt++;
            last_ack_cyc = cyc;
            if (exp_q.size() == 0) check("req_unexpected", mv_if.mv_op, OP_NONE);
            else check("req_op", mv_if.mv_op, exp_q.pop_front());
          end else begin
            age++;
          end
        end
      end
    end
  end

  // ---------------- pulse / valid-rise monitor ----------------
  initial begin
    logic valid_prev;
    valid_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (mv_if.mv_valid && !valid_prev) rise_q.push_back(cyc);
        if (rst_timer) begin
          rst_cnt++;
          check("rst_timer_after_ack", cyc, last_ack_cyc + 1);
        end
        if (lock_piece) begin
          lock_cnt++;
          check("lock_with_rst_timer", rst_timer, 1'b1);
        end
      end
      valid_prev = mv_if.mv_valid;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int r0, l0, q0, e;
    #1 rst = 1'b0;
    cycles(3);
    check("rst_valid", mv_if.mv_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_timer0", rst_timer, 1'b0);
    check("rst_lock0", lock_piece, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    cycles(2);

    // 1: reset while a request is outstanding
    btn_rot = 1'b1;
    cycles(1);
    btn_rot = 1'b0;
    check("t1_latency_valid", mv_if.mv_valid, 1'b1);
    check("t1_latency_op", mv_if.mv_op, OP_ROT);
    rst = 1'b0;
    #1;
    check("t1_async_valid", mv_if.mv_valid, 1'b0);
    check("t1_async_busy", busy, 1'b0);
    check("t1_async_rst_timer", rst_timer, 1'b0);
    check("t1_async_lock", lock_piece, 1'b0);
    cycles(2);
    rst = 1'b1;
    cycles(2);
    check("t1_idle_after", dbg_state, ST_IDLE);
    check("t1_no_valid_after", mv_if.mv_valid, 1'b0);

    // 2: gravity tick during REQ(LEFT) is latched and issued next
    q0 = req_cnt; r0 = rst_cnt;
    exp_q.push_back(OP_LEFT);
    exp_q.push_back(OP_DOWN);
    btn_left = 1'b1;
    cycles(1);
    btn_left = 1'b0;
    move_down_tick = 1'b1;
    cycles(1);
    move_down_tick = 1'b0;
    cycles(14);
    check("t2_drain", exp_q.size(), 0);
    check("t2_req_count", req_cnt - q0, 2);
    check("t2_grav_no_pulse", rst_cnt - r0, 0);

    // 3: DAS/ARR: events at E, E+4, E+6, E+8, E+10; only E, E+4, E+8 find IDLE
    q0 = req_cnt;
    rise_q.delete();
    e = cyc;
    repeat (3) exp_q.push_back(OP_LEFT);
    btn_left = 1'b1;
    cycles(12);
    btn_left = 1'b0;
    cycles(12);
    check("t3_drain", exp_q.size(), 0);
    check("t3_req_count", req_cnt - q0, 3);
    check("t3_rise_count", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check("t3_rise0", rise_q[0], e + 1);
      check("t3_rise1", rise_q[1], e + 5);
      check("t3_rise2", rise_q[2], e + 9);
    end

    // 4a: soft-down ok -> one rst_timer pulse, no lock
    r0 = rst_cnt; l0 = lock_cnt;
    exp_q.push_back(OP_DOWN);
    btn_down = 1'b1;
    cycles(1);
    btn_down = 1'b0;
    cycles(10);
    check("t4a_rst_pulse", rst_cnt - r0, 1);
    check("t4a_no_lock", lock_cnt - l0, 0);

    // 4b: soft-down collides -> lock + rst_timer, stay in LOCK until piece_active=0
    chk_ok = 1'b0;
    q0 = req_cnt;
    exp_q.push_back(OP_DOWN);
    btn_down = 1'b1;
    cycles(1);
    btn_down = 1'b0;
    cycles(5);
    chk_ok = 1'b1;
    check("t4b_lock_pulse", lock_cnt - l0, 1);
    check("t4b_rst_pulse", rst_cnt - r0, 2);
    check("t4b_state_lock", dbg_state, ST_LOCK);
    check("t4b_busy", busy, 1'b1);
    btn_rot = 1'b1;
    cycles(1);
    btn_rot = 1'b0;
    cycles(6);
    check("t4b_lock_holds", dbg_state, ST_LOCK);
    check("t4b_no_req_in_lock", req_cnt - q0, 1);
    piece_active = 1'b0;
    cycles(1);
    check("t4b_idle_after_spawn_gone", dbg_state, ST_IDLE);
    // no piece: edges and ticks are discarded
    btn_rot = 1'b1;
    move_down_tick = 1'b1;
    cycles(1);
    btn_rot = 1'b0;
    move_down_tick = 1'b0;
    cycles(3);
    piece_active = 1'b1;
    cycles(10);
    check("t4b_no_req_without_piece", req_cnt - q0, 1);
    check("t4b_busy_idle", busy, 1'b0);

    // 5: left+right together discarded; tick+rot together -> DOWN only
    q0 = req_cnt; r0 = rst_cnt;
    btn_left = 1'b1;
    btn_right = 1'b1;
    cycles(1);
    btn_left = 1'b0;
    btn_right = 1'b0;
    cycles(8);
    check("t5_lr_clash_no_req", req_cnt - q0, 0);
    exp_q.push_back(OP_DOWN);
    btn_rot = 1'b1;
    move_down_tick = 1'b1;
    cycles(1);
    btn_rot = 1'b0;
    move_down_tick = 1'b0;
    cycles(12);
    check("t5_tick_rot_count", req_cnt - q0, 1);
    check("t5_drain", exp_q.size(), 0);
    check("t5_grav_no_pulse", rst_cnt - r0, 0);

    // 6: hard drop
    q0 = req_cnt; l0 = lock_cnt;
`ifdef VETRIS_HARD_DROP_EN
    ok_q.push_back(1'b1);
    ok_q.push_back(1'b1);
    ok_q.push_back(1'b1);
    ok_q.push_back(1'b0);
    repeat (4) exp_q.push_back(OP_DOWN);
    btn_drop = 1'b1;
    cycles(1);
    btn_drop = 1'b0;
    cycles(16);
    check("t6_drop_reqs", req_cnt - q0, 4);
    check("t6_drop_lock", lock_cnt - l0, 1);
    check("t6_drop_state", dbg_state, ST_LOCK);
    piece_active = 1'b0;
    cycles(2);
    piece_active = 1'b1;
    cycles(2);
`else
    btn_drop = 1'b1;
    cycles(1);
    btn_drop = 1'b0;
    cycles(10);
    check("t6_drop_ignored", req_cnt - q0, 0);
    check("t6_drop_no_lock", lock_cnt - l0, 0);
`endif
    check("t6_idle", dbg_state, ST_IDLE);

    // 7: outstanding handshake completes after piece_active falls
    q0 = req_cnt;
    exp_q.push_back(OP_ROT);
    btn_rot = 1'b1;
    cycles(1);
    btn_rot = 1'b0;
    piece_active = 1'b0;
    cycles(8);
    check("t7_completes", req_cnt - q0, 1);
    check("t7_idle", busy, 1'b0);
    piece_active = 1'b1;
    cycles(4);

    check("final_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
